npu_stream_loader: RTL

- Parametrised successor to the NPU memory front end.
- Accepts host writes on a 32-bit bus and fills two on-chip buffers: an image buffer of packed words and a weight/bias buffer of single bytes.
- On command, replays both buffers as a byte stream toward the conv engine, using a valid/ready handshake with backpressure.
- Sits between the Avalon-style host register interface and the NPU datapath.

---
 rtl/npu_stream_loader.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/npu_stream_loader.sv
// -----------------------------------------------------------------------------
// npu_stream_loader
//
// Front end between the host register interface and the NPU datapath.
// Host writes fill an image buffer (packed DATA_W words) and then a
// weight/bias buffer (one BYTE_W element per write). On a run command both
// buffers are replayed as one byte stream with a valid/ready handshake.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   writedata    host write data (DATA_W)
//   wr_en        host write strobe, one beat per cycle
//   control_reg  [1:0] mode: 0 idle, 1 load, 2 run, 3 clear; [31:2] ignored
//   d_out        stream byte (BYTE_W)
//   d_valid      d_out holds a valid byte
//   d_ready      consumer accepts the byte
//   load_done    both buffers full
//   run_done     stream fully delivered
//   err_ovf      sticky: write arrived outside a load state
//   busy         high while loading or running
// -----------------------------------------------------------------------------
module npu_stream_loader #(
    parameter int DATA_W         = 32,
    parameter int BYTE_W         = 8,
    parameter int IMG_WORDS      = 224,
    parameter int WGT_BYTES      = 18815,
    parameter int PACK_MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] writedata,
    input  logic              wr_en,
    input  logic [31:0]       control_reg,
    output logic [BYTE_W-1:0] d_out,
    output logic              d_valid,
    input  logic              d_ready,
    output logic              load_done,
    output logic              run_done,
    output logic              err_ovf,
    output logic              busy
);

    localparam int BPW    = DATA_W / BYTE_W;
    localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int IMG_AW = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
    localparam int WGT_AW = (WGT_BYTES > 1) ? $clog2(WGT_BYTES) : 1;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BPW - 1);
    localparam logic [IMG_AW-1:0] IMG_LAST  = IMG_AW'(IMG_WORDS - 1);
    localparam logic [WGT_AW-1:0] WGT_LAST  = WGT_AW'(WGT_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IMG,
        S_LOAD_WGT,
        S_LOADED,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_reg;

    logic [1:0]  mode;
    logic [29:0] unused_ctrl;
    assign mode        = control_reg[1:0];
    assign unused_ctrl = control_reg[31:2];

    // Counters double as load write addresses and run read addresses.
    logic [IMG_AW-1:0] img_cnt_reg;
    logic [WGT_AW-1:0] wgt_cnt_reg;
    logic [LANE_W-1:0] lane_cnt_reg;
    logic              iss_img_reg;    // issuing image bytes (else weights)
    logic              iss_end_reg;    // every byte has been issued
    logic              mode2_prev_reg; // mode was 2 last cycle (for DONE replay)

    // Stage 2: RAM output registers plus the metadata of the byte in flight.
    logic              s2_valid_reg;
    logic              s2_is_img_reg;
    logic              s2_last_reg;
    logic [LANE_W-1:0] s2_lane_reg;
    logic              out_last_reg;

    logic [BYTE_W-1:0] d_out_reg;
    logic              d_valid_reg;
    logic              load_done_reg;
    logic              run_done_reg;
    logic              err_ovf_reg;

    // Whole read pipeline moves in lockstep whenever the output slot frees up;
    // the RAM stage holds its data (read enable low) while the consumer stalls.
    logic advance;
    logic issue;
    logic xfer;
    logic rd_en;
    logic img_we;
    logic wgt_we;

    assign advance = !d_valid_reg || d_ready;
    assign issue   = advance && !iss_end_reg;
    assign xfer    = d_valid_reg && d_ready;
    assign rd_en   = (state_reg == S_RUN) && advance;
    assign img_we  = (state_reg == S_LOAD_IMG) && wr_en && (mode != 2'd3);
    assign wgt_we  = (state_reg == S_LOAD_WGT) && wr_en && (mode != 2'd3);

    // ---------------------------------------------------------------- buffers
    logic [DATA_W-1:0] img_mem [IMG_WORDS];
    logic [BYTE_W-1:0] wgt_mem [WGT_BYTES];
    logic [DATA_W-1:0] img_rd_reg;
    logic [BYTE_W-1:0] wgt_rd_reg;

    always_ff @(posedge clk) begin
        if (img_we)
            img_mem[img_cnt_reg] <= writedata;
        if (rd_en)
            img_rd_reg <= img_mem[img_cnt_reg];
    end

    always_ff @(posedge clk) begin
        if (wgt_we)
            wgt_mem[wgt_cnt_reg] <= writedata[BYTE_W-1:0];
        if (rd_en)
            wgt_rd_reg <= wgt_mem[wgt_cnt_reg];
    end

    // Lane 0 is always the first byte emitted from a word.
    logic [BYTE_W-1:0] lane_bytes [BPW];

    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
            if (PACK_MSB_FIRST != 0) begin : g_msb
                assign lane_bytes[gi] = img_rd_reg[DATA_W-1-gi*BYTE_W -: BYTE_W];
            end else begin : g_lsb
                assign lane_bytes[gi] = img_rd_reg[gi*BYTE_W +: BYTE_W];
            end
        end
    endgenerate

    // ------------------------------------------------------------ control FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            img_cnt_reg    <= '0;
            wgt_cnt_reg    <= '0;
            lane_cnt_reg   <= '0;
            iss_img_reg    <= 1'b0;
            iss_end_reg    <= 1'b0;
            mode2_prev_reg <= 1'b0;
            s2_valid_reg   <= 1'b0;
            s2_is_img_reg  <= 1'b0;
            s2_last_reg    <= 1'b0;
            s2_lane_reg    <= '0;
            out_last_reg   <= 1'b0;
            d_out_reg      <= '0;
            d_valid_reg    <= 1'b0;
            load_done_reg  <= 1'b0;
            run_done_reg   <= 1'b0;
            err_ovf_reg    <= 1'b0;
        end else begin
            mode2_prev_reg <= (mode == 2'd2);

            if (mode == 2'd3) begin
                // Clear/abort from any state; buffer contents are kept.
                state_reg     <= S_IDLE;
                img_cnt_reg   <= '0;
                wgt_cnt_reg   <= '0;
                lane_cnt_reg  <= '0;
                iss_img_reg   <= 1'b0;
                iss_end_reg   <= 1'b0;
                s2_valid_reg  <= 1'b0;
                out_last_reg  <= 1'b0;
                d_out_reg     <= '0;
                d_valid_reg   <= 1'b0;
                load_done_reg <= 1'b0;
                run_done_reg  <= 1'b0;
                err_ovf_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    S_LOAD_IMG: begin
                        if (wr_en) begin
                            if (img_cnt_reg == IMG_LAST)
                                state_reg <= S_LOAD_WGT;
                            else
                                img_cnt_reg <= img_cnt_reg + IMG_AW'(1);
                        end
                    end

                    S_LOAD_WGT: begin
                        if (wr_en) begin
                            if (wgt_cnt_reg == WGT_LAST) begin
                                state_reg     <= S_LOADED;
                                load_done_reg <= 1'b1;
                            end else begin
                                wgt_cnt_reg <= wgt_cnt_reg + WGT_AW'(1);
                            end
                        end
                    end

                    S_RUN: begin
                        if (wr_en)
                            err_ovf_reg <= 1'b1;
                        if (advance) begin
                            s2_valid_reg  <= issue;
                            s2_is_img_reg <= iss_img_reg;
                            s2_lane_reg   <= lane_cnt_reg;
                            s2_last_reg   <= !iss_img_reg && (wgt_cnt_reg == WGT_LAST);
                            d_valid_reg   <= s2_valid_reg;
                            if (s2_valid_reg) begin
                                d_out_reg    <= s2_is_img_reg ? lane_bytes[s2_lane_reg] : wgt_rd_reg;
                                out_last_reg <= s2_last_reg;
                            end
                        end
                        if (issue) begin
                            if (iss_img_reg) begin
                                if (lane_cnt_reg == LANE_LAST) begin
                                    lane_cnt_reg <= '0;
                                    if (img_cnt_reg == IMG_LAST)
                                        iss_img_reg <= 1'b0;
                                    else
                                        img_cnt_reg <= img_cnt_reg + IMG_AW'(1);
                                end else begin
                                    lane_cnt_reg <= lane_cnt_reg + LANE_W'(1);
                                end
                            end else begin
                                if (wgt_cnt_reg == WGT_LAST)
                                    iss_end_reg <= 1'b1;
                                else
                                    wgt_cnt_reg <= wgt_cnt_reg + WGT_AW'(1);
                            end
                        end
                        // Nothing is in flight behind the last byte, so
                        // d_valid falls on the same edge via s2_valid_reg.
                        if (xfer && out_last_reg) begin
                            state_reg    <= S_DONE;
                            run_done_reg <= 1'b1;
                        end
                    end

                    default: begin
                        // S_IDLE, S_LOADED, S_DONE: writes are dropped.
                        if (wr_en)
                            err_ovf_reg <= 1'b1;
                        if ((mode == 2'd2) &&
                            ((state_reg == S_LOADED) ||
                             ((state_reg == S_DONE) && !mode2_prev_reg))) begin
                            state_reg    <= S_RUN;
                            img_cnt_reg  <= '0;
                            wgt_cnt_reg  <= '0;
                            lane_cnt_reg <= '0;
                            iss_img_reg  <= 1'b1;
                            iss_end_reg  <= 1'b0;
                            s2_valid_reg <= 1'b0;
                            out_last_reg <= 1'b0;
                            run_done_reg <= 1'b0;
                        end else if (mode == 2'd1) begin
                            state_reg     <= S_LOAD_IMG;
                            img_cnt_reg   <= '0;
                            wgt_cnt_reg   <= '0;
                            lane_cnt_reg  <= '0;
                            load_done_reg <= 1'b0;
                            run_done_reg  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign d_out     = d_out_reg;
    assign d_valid   = d_valid_reg;
    assign load_done = load_done_reg;
    assign run_done  = run_done_reg;
    assign err_ovf   = err_ovf_reg;
    assign busy      = (state_reg == S_LOAD_IMG) || (state_reg == S_LOAD_WGT) ||
                       (state_reg == S_RUN);

endmodule
